// File: rtl/timer_alarm_if.sv
// Bus bundle for timer_alarm: single-cycle register access plus interrupt.
// The read-data signal is named dout because "do" is a reserved word in SystemVerilog.
interface timer_alarm_if;
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] di;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output cs,
        output we,
        output addr,
        output di,
        input  dout,
        input  irq
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  di,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_alarm.sv
// Prescaled 32-bit up-counter with compare match, periodic/one-shot modes,
// sticky W1C match flag and a registered level interrupt.
// Register map: 0 COUNT, 1 CMP, 2 CTRL {IE,PER,EN}, 3 STATUS {MF}.
module timer_alarm #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic          clk,
    input  logic          rst,
    timer_alarm_if.slave  bus
);

    localparam logic [15:0] PSC_LAST = 16'(CLK_DIV - 1);

    localparam logic [1:0] A_COUNT  = 2'd0;
    localparam logic [1:0] A_CMP    = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [15:0] psc;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        en;
    logic        per;
    logic        ie;
    logic        mf;
    logic [31:0] rdata;

    logic wr;
    logic wr_count;
    logic wr_cmp;
    logic wr_ctrl;
    logic wr_status;
    logic tick;
    logic match;

    // Bus decode, tick and match qualification
    always_comb begin
        wr        = bus.cs & bus.we;
        wr_count  = wr && (bus.addr == A_COUNT);
        wr_cmp    = wr && (bus.addr == A_CMP);
        wr_ctrl   = wr && (bus.addr == A_CTRL);
        wr_status = wr && (bus.addr == A_STATUS);
        tick      = en && (psc == PSC_LAST);
        // A COUNT write in the tick cycle suppresses both increment and match
        match     = tick && !wr_count && (count == cmp);
    end

    // Prescaler: held at 0 while disabled, wraps at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            psc <= '0;
        end else if (psc == PSC_LAST) begin
            psc <= '0;
        end else begin
            psc <= psc + 16'd1;
        end
    end

    // COUNT: bus write wins, else increment or periodic reload on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.di;
        end else if (tick) begin
            if (match && per) begin
                count <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // CMP register
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= '1;
        end else if (wr_cmp) begin
            cmp <= bus.di;
        end
    end

    // CTRL: bus write wins over the one-shot auto-clear of EN
    always_ff @(posedge clk) begin
        if (rst) begin
            en  <= 1'b0;
            per <= 1'b0;
            ie  <= 1'b0;
        end else if (wr_ctrl) begin
            en  <= bus.di[0];
            per <= bus.di[1];
            ie  <= bus.di[2];
        end else if (match && !per) begin
            en  <= 1'b0;
        end
    end

    // STATUS.MF: match sets, W1C clears, set wins on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            mf <= 1'b0;
        end else if (match) begin
            mf <= 1'b1;
        end else if (wr_status && bus.di[0]) begin
            mf <= 1'b0;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.irq <= 1'b0;
        end else begin
            bus.irq <= mf & ie;
        end
    end

    // Read mux for the addressed register
    always_comb begin
        rdata = '0;
        case (bus.addr)
            A_COUNT:  rdata = count;
            A_CMP:    rdata = cmp;
            A_CTRL:   rdata = {29'd0, ie, per, en};
            A_STATUS: rdata = {31'd0, mf};
            default:  rdata = '0;
        endcase
    end

    // Read data: one-cycle latency, zero after idle or write cycles (OR-bus)
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout <= '0;
        end else if (bus.cs && !bus.we) begin
            bus.dout <= rdata;
        end else begin
            bus.dout <= '0;
        end
    end

endmodule

// File: tb/tb_timer_alarm.sv
// Scoreboard bench for timer_alarm: CLK_DIV=12 main instance plus a CLK_DIV=1 instance.
module tb_timer_alarm;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    timer_alarm_if bus ();
    timer_alarm_if bus1 ();

    timer_alarm #(.CLK_DIV(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    timer_alarm #(.CLK_DIV(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count; at a negedge, cyc = index of the most recent posedge
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int wc);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.di = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.di = '0;
        wc = cyc;
        checks++;
        if (bus.dout !== 32'd0) begin
            errors++;
            $display("FAIL dout_after_write got %h want 00000000", bus.dout);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] expv, input string nm);
        logic [31:0] e;
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.cs = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.dout !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, bus.dout, e);
        end
        @(negedge clk);
        checks++;
        if (bus.dout !== 32'd0) begin
            errors++;
            $display("FAIL %s_idle got %h want 00000000", nm, bus.dout);
        end
    endtask

    task automatic wait_irq(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.irq === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic cleanup();
        int w;
        bus_write(2'd2, 32'd0, w);
        bus_write(2'd3, 32'd1, w);
        bus_write(2'd0, 32'd0, w);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", bus.irq);
        end
        checks++;
        if (bus.dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_dout got %h want 00000000", bus.dout);
        end
        bus_read(2'd0, 32'd0, "reset_count");
        bus_read(2'd1, 32'hFFFF_FFFF, "reset_cmp");
        bus_read(2'd2, 32'd0, "reset_ctrl");
        bus_read(2'd3, 32'd0, "reset_status");
        repeat (30) @(negedge clk);
        bus_read(2'd0, 32'd0, "idle_count");
    endtask

    task automatic test_periodic();
        int w, w2, at;
        bus_write(2'd1, 32'd3, w);
        bus_write(2'd2, 32'd7, w);
        wait_irq(200, at);
        checks++;
        if (at - w !== 49) begin
            errors++;
            $display("FAIL periodic_irq_rise got %0d want 49", at - w);
        end
        bus_read(2'd0, 32'd0, "periodic_count_reload");
        bus_read(2'd3, 32'd1, "periodic_mf");
        bus_write(2'd3, 32'd1, w2);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_clear got %b want 0", bus.irq);
        end
        wait_irq(200, at);
        checks++;
        if (at - w !== 97) begin
            errors++;
            $display("FAIL periodic_second_rise got %0d want 97", at - w);
        end
        cleanup();
    endtask

    task automatic test_oneshot();
        int w, at;
        bus_write(2'd1, 32'd2, w);
        bus_write(2'd2, 32'd5, w);
        wait_irq(200, at);
        checks++;
        if (at - w !== 37) begin
            errors++;
            $display("FAIL oneshot_irq_rise got %0d want 37", at - w);
        end
        bus_read(2'd0, 32'd3, "oneshot_count");
        bus_read(2'd2, 32'd4, "oneshot_ctrl");
        repeat (30) @(negedge clk);
        bus_read(2'd0, 32'd3, "oneshot_frozen");
        cleanup();
    endtask

    task automatic test_wrap();
        int w;
        bus_write(2'd1, 32'd5, w);
        bus_write(2'd0, 32'hFFFF_FFFF, w);
        bus_write(2'd2, 32'd1, w);
        wait_until(w + 12);
        bus_read(2'd0, 32'd0, "wrap_count");
        bus_read(2'd3, 32'd0, "wrap_mf");
        cleanup();
    endtask

    task automatic test_count_write_collision();
        int w;
        bus_write(2'd1, 32'd0, w);
        bus_write(2'd2, 32'd1, w);
        wait_until(w + 11);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.di = 32'h55;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.di = '0;
        bus_read(2'd0, 32'h55, "cntwr_count");
        bus_read(2'd3, 32'd0, "cntwr_no_match");
        cleanup();
    endtask

    task automatic test_ctrl_collision();
        int w;
        bus_write(2'd1, 32'd0, w);
        bus_write(2'd2, 32'd5, w);
        wait_until(w + 11);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd2; bus.di = 32'd1;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.di = '0;
        bus_read(2'd2, 32'd1, "ctrlwr_ctrl");
        bus_read(2'd0, 32'd1, "ctrlwr_count");
        bus_read(2'd3, 32'd1, "ctrlwr_mf");
        cleanup();
    endtask

    task automatic test_w1c_collision();
        int w, w2;
        bus_write(2'd1, 32'd0, w);
        bus_write(2'd2, 32'd5, w);
        wait_until(w + 11);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd3; bus.di = 32'd1;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.di = '0;
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_set_wins_irq got %b want 1", bus.irq);
        end
        bus_read(2'd3, 32'd1, "w1c_set_wins_mf");
        bus_write(2'd3, 32'd1, w2);
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear_irq got %b want 0", bus.irq);
        end
        bus_read(2'd3, 32'd0, "w1c_clear_mf");
        cleanup();
    endtask

    task automatic test_div1();
        int w;
        logic [31:0] e;
        @(negedge clk);
        bus1.cs = 1'b1; bus1.we = 1'b1; bus1.addr = 2'd1; bus1.di = 32'd2;
        @(negedge clk);
        bus1.addr = 2'd2; bus1.di = 32'd5;
        @(negedge clk);
        bus1.cs = 1'b0; bus1.we = 1'b0; bus1.di = '0;
        w = cyc;
        @(negedge clk);
        bus1.cs = 1'b1; bus1.addr = 2'd0;
        exp_q.push_back(32'(cyc - w));
        @(negedge clk);
        bus1.cs = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus1.dout !== e) begin
            errors++;
            $display("FAIL div1_count_mid got %h want %h", bus1.dout, e);
        end
        repeat (6) @(negedge clk);
        bus1.cs = 1'b1; bus1.addr = 2'd0;
        exp_q.push_back(32'd3);
        @(negedge clk);
        bus1.cs = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus1.dout !== e) begin
            errors++;
            $display("FAIL div1_count_final got %h want %h", bus1.dout, e);
        end
        checks++;
        if (bus1.irq !== 1'b1) begin
            errors++;
            $display("FAIL div1_irq got %b want 1", bus1.irq);
        end
    endtask

    task automatic test_reset_mid();
        int w, at;
        bus_write(2'd1, 32'd1, w);
        bus_write(2'd2, 32'd7, w);
        wait_irq(100, at);
        checks++;
        if (at - w !== 25) begin
            errors++;
            $display("FAIL rstmid_irq_rise got %0d want 25", at - w);
        end
        rst = 1'b1;
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        bus.cs = 1'b0;
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_irq got %b want 0", bus.irq);
        end
        checks++;
        if (bus.dout !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_dout got %h want 00000000", bus.dout);
        end
        bus_read(2'd0, 32'd0, "rstmid_count");
        bus_read(2'd1, 32'hFFFF_FFFF, "rstmid_cmp");
        bus_read(2'd2, 32'd0, "rstmid_ctrl");
        bus_read(2'd3, 32'd0, "rstmid_status");
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.di = '0;
        bus1.cs = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.di = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_wrap();
        test_count_write_collision();
        test_ctrl_collision();
        test_w1c_collision();
        test_div1();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
